// File: rtl/psum_sched_pkg.sv
// Shared encodings and helpers for the partial-sum buffer scheduler.
// Imported by the top and its drain output register.
package psum_sched_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ACC_RD  = 3'd1,
        ACC_WR  = 3'd2,
        DRN_RD  = 3'd3,
        DRN_CAP = 3'd4
    } state_e;

    typedef enum logic {
        GNT_ACC   = 1'b0,
        GNT_DRAIN = 1'b1
    } grant_e;

    // Signed add overflows when both operands agree in sign and the sum does not.
    function automatic logic add_ovf(
        input logic a_msb,
        input logic b_msb,
        input logic s_msb
    );
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/psum_buffer_scheduler_if.sv
// Accumulate, drain-stream and scratchpad signals of the psum scheduler.
// slave is the scheduler side, master the surrounding system side.
interface psum_buffer_scheduler_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    logic              acc_req;
    logic              acc_first;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_data;
    logic              acc_ack;
    logic              acc_ovf;
    logic              drain_start;
    logic [ADDR_W:0]   drain_len;
    logic              drain_busy;
    logic              drain_valid;
    logic              drain_ready;
    logic [DATA_W-1:0] drain_data;
    logic              drain_last;
    logic              drain_done;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  acc_req, acc_first, acc_addr, acc_data,
        output acc_ack, acc_ovf,
        input  drain_start, drain_len, drain_ready,
        output drain_busy, drain_valid, drain_data,
        output drain_last, drain_done,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output acc_req, acc_first, acc_addr, acc_data,
        input  acc_ack, acc_ovf,
        output drain_start, drain_len, drain_ready,
        input  drain_busy, drain_valid, drain_data,
        input  drain_last, drain_done,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/psum_drain_out.sv
// Drain output holding register: valid/ready/last plus the done pulse.
// Data stays stable while valid waits for ready.
module psum_drain_out
    import psum_sched_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cap,
    input  logic [DATA_W-1:0] cap_data,
    input  logic              cap_last,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic              last,
    output logic              done,
    output logic              fire_last
);
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              fire;

    always_comb begin
        fire      = valid_q & ready;
        fire_last = fire & last_q;
        valid_d   = valid_q;
        last_d    = last_q;
        data_d    = data_q;
        done_d    = fire_last;
        if (cap) begin
            valid_d = 1'b1;
            last_d  = cap_last;
            data_d  = cap_data;
        end else if (fire) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            last_q  <= last_d;
            done_q  <= done_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign last  = last_q;
    assign done  = done_q;
    assign data  = data_q;
endmodule

// File: rtl/psum_buffer_scheduler.sv
// Single-port psum scratchpad shared by accumulate RMW and sequential drain.
// Round-robin grant, one memory transaction at a time.
module psum_buffer_scheduler
    import psum_sched_pkg::*;
#(
    parameter int DATA_W         = 16,
    parameter int ADDR_W         = 4,
    parameter bit CLEAR_ON_DRAIN = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    psum_buffer_scheduler_if.slave bus
);
    localparam logic [ADDR_W-1:0] PTR_ONE = 1;
    localparam logic [ADDR_W:0]   REM_ONE = 1;

    state_e            state_q, state_d;
    grant_e            last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] a_addr_q, a_addr_d;
    logic [ADDR_W:0]   rem_q, rem_d;
    logic [DATA_W-1:0] a_data_q, a_data_d;
    logic              a_first_q, a_first_d;
    logic              busy_q, busy_d;
    logic              ovf_q, ovf_d;
    logic              zdone_q, zdone_d;
    logic [DATA_W-1:0] acc_sum;
    logic              acc_elig, drn_elig;
    logic              cap, out_valid, out_done, fire_last;
    logic              mem_en, mem_we, acc_ack;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    assign acc_sum  = bus.mem_rdata + a_data_q;
    assign acc_elig = bus.acc_req;
    assign drn_elig = busy_q & (rem_q != '0) & ~out_valid;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        ptr_d        = ptr_q;
        rem_d        = rem_q;
        a_addr_d     = a_addr_q;
        a_data_d     = a_data_q;
        a_first_d    = a_first_q;
        busy_d       = busy_q;
        ovf_d        = ovf_q;
        zdone_d      = 1'b0;
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        acc_ack      = 1'b0;
        cap          = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (acc_elig && (!drn_elig || last_grant_q == GNT_DRAIN)) begin
                    state_d      = bus.acc_first ? ACC_WR : ACC_RD;
                    last_grant_d = GNT_ACC;
                end else if (drn_elig) begin
                    state_d      = DRN_RD;
                    last_grant_d = GNT_DRAIN;
                end
                if (acc_elig || drn_elig) begin
                    a_addr_d  = bus.acc_addr;
                    a_data_d  = bus.acc_data;
                    a_first_d = bus.acc_first;
                end
            end
            ACC_RD: begin
                mem_en   = 1'b1;
                mem_addr = a_addr_q;
                state_d  = ACC_WR;
            end
            ACC_WR: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = a_addr_q;
                mem_wdata = a_first_q ? a_data_q : acc_sum;
                acc_ack   = 1'b1;
                if (!a_first_q && add_ovf(bus.mem_rdata[DATA_W-1],
                        a_data_q[DATA_W-1], acc_sum[DATA_W-1]))
                    ovf_d = 1'b1;
                state_d   = IDLE;
            end
            DRN_RD: begin
                mem_en   = 1'b1;
                mem_addr = ptr_q;
                state_d  = DRN_CAP;
            end
            DRN_CAP: begin
                cap      = 1'b1;
                ptr_d    = ptr_q + PTR_ONE;
                rem_d    = rem_q - REM_ONE;
                mem_en   = CLEAR_ON_DRAIN;
                mem_we   = CLEAR_ON_DRAIN;
                mem_addr = ptr_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A zero-length drain completes immediately without ever going busy.
        if (bus.drain_start && !busy_q) begin
            ptr_d   = '0;
            rem_d   = bus.drain_len;
            busy_d  = (bus.drain_len != '0);
            zdone_d = (bus.drain_len == '0);
        end
        if (fire_last)
            busy_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_grant_q <= GNT_DRAIN;
            ptr_q        <= '0;
            rem_q        <= '0;
            a_addr_q     <= '0;
            a_data_q     <= '0;
            a_first_q    <= 1'b0;
            busy_q       <= 1'b0;
            ovf_q        <= 1'b0;
            zdone_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            ptr_q        <= ptr_d;
            rem_q        <= rem_d;
            a_addr_q     <= a_addr_d;
            a_data_q     <= a_data_d;
            a_first_q    <= a_first_d;
            busy_q       <= busy_d;
            ovf_q        <= ovf_d;
            zdone_q      <= zdone_d;
        end
    end

    psum_drain_out #(.DATA_W(DATA_W)) u_out (
        .clk       (clk),
        .reset     (reset),
        .cap       (cap),
        .cap_data  (bus.mem_rdata),
        .cap_last  (rem_q == REM_ONE),
        .ready     (bus.drain_ready),
        .valid     (out_valid),
        .data      (bus.drain_data),
        .last      (bus.drain_last),
        .done      (out_done),
        .fire_last (fire_last)
    );

    assign bus.drain_valid = out_valid;
    assign bus.drain_done  = out_done | zdone_q;
    assign bus.drain_busy  = busy_q;
    assign bus.acc_ack     = acc_ack;
    assign bus.acc_ovf     = ovf_q;
    assign bus.mem_en      = mem_en;
    assign bus.mem_we      = mem_we;
    assign bus.mem_addr    = mem_addr;
    assign bus.mem_wdata   = mem_wdata;
endmodule

// File: tb/tb_psum_buffer_scheduler.sv
// Bench for psum_buffer_scheduler: SRAM model, behavioural psum reference,
// randomized accumulate and drain traffic.
module tb_psum_buffer_scheduler;
    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    psum_buffer_scheduler_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    psum_buffer_scheduler #(
        .DATA_W(DW), .ADDR_W(AW), .CLEAR_ON_DRAIN(1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [DW-1:0] sram [DEPTH];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) sram[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata <= sram[bus.mem_addr];
        end
    end

    int chk  = 0;
    int pass = 0;
    int ref_mem [DEPTH];
    bit ref_ovf;

    logic [DW-1:0] got_d [$];
    bit            got_l [$];
    int            done_cnt;
    int            unstable;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int wrap16(input int v);
        return ((v + 32768) & 32'hFFFF) - 32768;
    endfunction

    task automatic ref_acc(input bit first, input int a, input int v);
        int s;
        if (first) begin
            s = v;
        end else begin
            s = ref_mem[a] + v;
            if (s > 32767 || s < -32768) ref_ovf = 1'b1;
        end
        ref_mem[a] = wrap16(s);
    endtask

    function automatic int mem_val(input int a);
        return int'($signed(sram[a]));
    endfunction

    task automatic backdoor(input int a, input int v);
        sram[a]    = 16'(v);
        ref_mem[a] = wrap16(v);
    endtask

    task automatic idle_inputs();
        bus.acc_req     = 1'b0;
        bus.acc_first   = 1'b0;
        bus.acc_addr    = '0;
        bus.acc_data    = '0;
        bus.drain_start = 1'b0;
        bus.drain_len   = '0;
        bus.drain_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        step();
        step();
        reset   = 1'b1;
        ref_ovf = 1'b0;
        step();
    endtask

    task automatic do_acc(input bit first, input int a, input int v,
                          output int lat);
        bus.acc_req   = 1'b1;
        bus.acc_first = first;
        bus.acc_addr  = 4'(a);
        bus.acc_data  = 16'(v);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (bus.acc_ack) begin
                lat = k;
                break;
            end
        end
        if (lat != 0) step();
        bus.acc_req = 1'b0;
        ref_acc(first, a, v);
    endtask

    task automatic collect_drain(input int pct);
        int       tail;
        bit       hold;
        logic [DW-1:0] prev;
        got_d.delete();
        got_l.delete();
        done_cnt = 0;
        unstable = 0;
        tail = -1;
        hold = 1'b0;
        prev = '0;
        for (int c = 0; c < 3000; c++) begin
            if (bus.drain_done) begin
                done_cnt++;
                if (tail < 0) tail = 4;
            end
            if (tail == 0) break;
            if (tail > 0) tail--;
            if (hold && (!bus.drain_valid || bus.drain_data !== prev))
                unstable++;
            bus.drain_ready = ($urandom_range(0, 99) < pct);
            if (bus.drain_valid && bus.drain_ready) begin
                got_d.push_back(bus.drain_data);
                got_l.push_back(bus.drain_last);
            end
            hold = bus.drain_valid && !bus.drain_ready;
            prev = bus.drain_data;
            step();
        end
        bus.drain_ready = 1'b0;
    endtask

    task automatic start_drain(input int len);
        bus.drain_len   = 5'(len);
        bus.drain_start = 1'b1;
        step();
        bus.drain_start = 1'b0;
    endtask

    task automatic check_drain(input string nm, input int len, input int exp[$]);
        chk++;
        if (got_d.size() != len) begin
            $display("FAIL %s_count: got %0d words want %0d", nm, got_d.size(), len);
        end else pass++;
        for (int i = 0; i < len && i < got_d.size(); i++) begin
            chk++;
            if (int'($signed(got_d[i])) !== exp[i] || got_l[i] !== (i == len - 1))
                $display("FAIL %s_word%0d: got %0d last=%0b want %0d last=%0b",
                         nm, i, $signed(got_d[i]), got_l[i], exp[i], i == len - 1);
            else pass++;
        end
        chk++;
        if (done_cnt != 1 || unstable != 0)
            $display("FAIL %s_done: got done=%0d unstable=%0d want 1 and 0",
                     nm, done_cnt, unstable);
        else pass++;
        for (int i = 0; i < len; i++) begin
            chk++;
            if (mem_val(i) !== 0)
                $display("FAIL %s_clear%0d: got %0d want 0", nm, i, mem_val(i));
            else pass++;
        end
    endtask

    function automatic logic [63:0] out_vec();
        return {bus.acc_ack, bus.acc_ovf, bus.drain_busy, bus.drain_valid,
                bus.drain_data, bus.drain_last, bus.drain_done, bus.mem_en,
                bus.mem_we, bus.mem_addr, bus.mem_wdata};
    endfunction

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        step();
        step();
        chk++;
        if (out_vec() !== '0) $display("FAIL reset_hold: got %h want 0", out_vec());
        else pass++;
        reset = 1'b1;
        ref_ovf = 1'b0;
        step();
        chk++;
        if (out_vec() !== '0) $display("FAIL reset_idle: got %h want 0", out_vec());
        else pass++;
    endtask

    task automatic test_accumulate();
        int lat;
        do_acc(1'b1, 3, 5, lat);
        chk++;
        if (lat !== 1) $display("FAIL acc_first_lat: got %0d want 1", lat);
        else pass++;
        do_acc(1'b0, 3, 7, lat);
        chk++;
        if (lat !== 2) $display("FAIL acc_rmw_lat: got %0d want 2", lat);
        else pass++;
        chk++;
        if (mem_val(3) !== 12) $display("FAIL acc_sum3: got %0d want 12", mem_val(3));
        else pass++;
        for (int n = 0; n < 24; n++) begin
            bit first;
            int a, v;
            first = ($urandom_range(0, 3) == 0);
            a = $urandom_range(0, DEPTH - 1);
            v = wrap16(int'($urandom_range(0, 65535)));
            do_acc(first, a, v, lat);
            chk++;
            if (lat !== (first ? 1 : 2) || mem_val(a) !== ref_mem[a] ||
                bus.acc_ovf !== ref_ovf)
                $display("FAIL acc_rand%0d: got lat=%0d mem=%0d ovf=%0b want %0d %0d %0b",
                         n, lat, mem_val(a), bus.acc_ovf, first ? 1 : 2,
                         ref_mem[a], ref_ovf);
            else pass++;
        end
    endtask

    task automatic test_overflow();
        int lat;
        do_reset();
        do_acc(1'b1, 2, 32767, lat);
        do_acc(1'b0, 2, 1, lat);
        chk++;
        if (sram[2] !== 16'h8000 || bus.acc_ovf !== 1'b1)
            $display("FAIL ovf_set: got mem=%h ovf=%0b want 8000 1", sram[2], bus.acc_ovf);
        else pass++;
        do_acc(1'b0, 2, 1, lat);
        do_acc(1'b1, 4, -1, lat);
        chk++;
        if (sram[2] !== 16'h8001 || bus.acc_ovf !== 1'b1)
            $display("FAIL ovf_sticky: got mem=%h ovf=%0b want 8001 1", sram[2], bus.acc_ovf);
        else pass++;
        do_reset();
        chk++;
        if (bus.acc_ovf !== 1'b0) $display("FAIL ovf_reset: got %0b want 0", bus.acc_ovf);
        else pass++;
    endtask

    task automatic test_drain();
        int exp[$];
        for (int i = 0; i < 4; i++) backdoor(i, i + 1);
        exp = {1, 2, 3, 4};
        start_drain(4);
        collect_drain(100);
        for (int i = 0; i < 4; i++) ref_mem[i] = 0;
        check_drain("drain4", 4, exp);
        for (int r = 0; r < 3; r++) begin
            int len;
            len = $urandom_range(1, DEPTH);
            exp.delete();
            for (int i = 0; i < DEPTH; i++)
                backdoor(i, int'($urandom_range(0, 65535)));
            for (int i = 0; i < len; i++) begin
                exp.push_back(ref_mem[i]);
                ref_mem[i] = 0;
            end
            start_drain(len);
            collect_drain(60);
            check_drain($sformatf("drain_rand%0d", r), len, exp);
        end
    endtask

    task automatic test_backpressure();
        int exp[$];
        int lat, bad, waited;
        logic [DW-1:0] d0;
        for (int i = 0; i < 4; i++) backdoor(i, int'($urandom_range(0, 65535)));
        backdoor(9, 0);
        for (int i = 0; i < 4; i++) begin
            exp.push_back(ref_mem[i]);
            ref_mem[i] = 0;
        end
        start_drain(4);
        waited = 0;
        while (!bus.drain_valid && waited < 20) begin
            step();
            waited++;
        end
        d0 = bus.drain_data;
        chk++;
        if (!bus.drain_valid || int'($signed(d0)) !== exp[0])
            $display("FAIL bp_first: got valid=%0b data=%0d want 1 %0d",
                     bus.drain_valid, $signed(d0), exp[0]);
        else pass++;
        bad = 0;
        for (int n = 0; n < 5; n++) begin
            do_acc(1'b0, 9, $urandom_range(1, 100), lat);
            if (lat != 2) bad++;
        end
        chk++;
        if (bad != 0 || mem_val(9) !== ref_mem[9])
            $display("FAIL bp_acc: got %0d slow acks mem9=%0d want 0 %0d",
                     bad, mem_val(9), ref_mem[9]);
        else pass++;
        chk++;
        if (!bus.drain_valid || bus.drain_data !== d0)
            $display("FAIL bp_hold: got valid=%0b data=%h want 1 %h",
                     bus.drain_valid, bus.drain_data, d0);
        else pass++;
        collect_drain(100);
        check_drain("bp", 4, exp);
    endtask

    task automatic test_alternate();
        byte ev[$];
        int  exp[$];
        int  nd, err, c;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            backdoor(i, int'($urandom_range(0, 65535)));
            exp.push_back(ref_mem[i]);
        end
        got_d.delete();
        bus.drain_len   = 5'd8;
        bus.drain_start = 1'b1;
        step();
        bus.drain_start = 1'b0;
        bus.drain_ready = 1'b1;
        bus.acc_req     = 1'b1;
        bus.acc_first   = 1'b1;
        bus.acc_addr    = 4'd15;
        bus.acc_data    = 16'($urandom_range(0, 65535));
        nd = 0;
        c  = 0;
        while (nd < 8 && c < 400) begin
            step();
            c++;
            if (bus.acc_ack) begin
                ev.push_back("A");
                ref_acc(1'b1, 15, int'($signed(bus.acc_data)));
                bus.acc_data = 16'($urandom_range(0, 65535));
            end
            if (bus.drain_valid) begin
                ev.push_back("D");
                got_d.push_back(bus.drain_data);
                nd++;
            end
        end
        bus.acc_req = 1'b0;
        step();
        err = (ev.size() == 16) ? 0 : 1;
        for (int i = 0; i < ev.size() && i < 16; i++)
            if (ev[i] != ((i % 2 == 0) ? "A" : "D")) err++;
        chk++;
        if (err != 0)
            $display("FAIL alt_order: got %0d events %0d out of order want 16 and 0",
                     ev.size(), err);
        else pass++;
        chk++;
        if (bus.drain_done !== 1'b1 || bus.drain_busy !== 1'b0)
            $display("FAIL alt_done: got done=%0b busy=%0b want 1 0",
                     bus.drain_done, bus.drain_busy);
        else pass++;
        for (int i = 0; i < 8 && i < got_d.size(); i++) begin
            chk++;
            if (int'($signed(got_d[i])) !== exp[i])
                $display("FAIL alt_word%0d: got %0d want %0d", i, $signed(got_d[i]), exp[i]);
            else pass++;
        end
        chk++;
        if (mem_val(15) !== ref_mem[15])
            $display("FAIL alt_acc: got %0d want %0d", mem_val(15), ref_mem[15]);
        else pass++;
        step();
    endtask

    task automatic test_reset_mid_and_len0();
        int dc, en_seen, busy_seen;
        bit d_first;
        backdoor(5, 100);
        bus.acc_req   = 1'b1;
        bus.acc_first = 1'b0;
        bus.acc_addr  = 4'd5;
        bus.acc_data  = 16'd3;
        step();
        chk++;
        if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 4'd5)
            $display("FAIL mid_rd: got en=%0b we=%0b addr=%0d want 1 0 5",
                     bus.mem_en, bus.mem_we, bus.mem_addr);
        else pass++;
        reset = 1'b0;
        bus.acc_req = 1'b0;
        step();
        chk++;
        if (out_vec() !== '0) $display("FAIL mid_reset_out: got %h want 0", out_vec());
        else pass++;
        reset = 1'b1;
        ref_ovf = 1'b0;
        step();
        step();
        chk++;
        if (mem_val(5) !== 100 || bus.mem_en !== 1'b0)
            $display("FAIL mid_nowrite: got mem=%0d en=%0b want 100 0",
                     mem_val(5), bus.mem_en);
        else pass++;
        start_drain(0);
        d_first = bus.drain_done;
        dc = 0;
        en_seen = 0;
        busy_seen = 0;
        for (int c = 0; c < 6; c++) begin
            if (bus.drain_done) dc++;
            if (bus.mem_en) en_seen++;
            if (bus.drain_busy) busy_seen++;
            step();
        end
        chk++;
        if (d_first !== 1'b1 || dc != 1)
            $display("FAIL len0_done: got first=%0b pulses=%0d want 1 1", d_first, dc);
        else pass++;
        chk++;
        if (en_seen != 0 || busy_seen != 0)
            $display("FAIL len0_quiet: got en=%0d busy=%0d want 0 0", en_seen, busy_seen);
        else pass++;
    endtask

    initial begin
        bus.mem_rdata = '0;
        for (int i = 0; i < DEPTH; i++) backdoor(i, 0);
        ref_ovf = 1'b0;
        test_reset();
        test_accumulate();
        test_overflow();
        test_drain();
        test_backpressure();
        test_alternate();
        test_reset_mid_and_len0();
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end
endmodule

// File: doc/psum_buffer_scheduler.md
Name: psum_buffer_scheduler

Overview:
- Owns the single-port partial-sum scratchpad and shares it between two requesters.
- Requester 1, accumulate (from the PE datapath): read-modify-write of one psum word per request.
- Requester 2, drain: sequential readout of N words to the output stream, optionally zeroing each word after it is read.
- Sits between the main controller/PE result path and the psum SRAM; round-robin arbitration runs one memory transaction at a time.

Parameters:
DATA_W, 16, psum word width (signed, two's complement)
ADDR_W, 4, scratchpad address width; depth = 2^ADDR_W
CLEAR_ON_DRAIN, 1, when 1, write 0 to each entry in the cycle its drained value is captured

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low reset
acc_req  in  1  accumulate request; held high until acc_ack
acc_first  in  1  first contribution: write acc_data directly, no read
acc_addr  in  ADDR_W  target entry
acc_data  in  DATA_W  value to add
acc_ack  out  1  one-cycle pulse when the write-back is issued
acc_ovf  out  1  sticky signed-overflow flag
drain_start  in  1  pulse to begin a drain of drain_len entries starting at address 0
drain_len  in  ADDR_W+1  number of entries, 0..2^ADDR_W
drain_busy  out  1  drain in progress
drain_valid  out  1  drain_data valid
drain_ready  in  1  downstream accepts
drain_data  out  DATA_W  drained word
drain_last  out  1  qualifies the final drained word
drain_done  out  1  one-cycle pulse on acceptance of the last word
mem_en  out  1  SRAM enable
mem_we  out  1  SRAM write enable
mem_addr  out  ADDR_W  SRAM address
mem_wdata  out  DATA_W  SRAM write data
mem_rdata  in  DATA_W  SRAM read data; valid the cycle after a read

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE; ptr=0; remaining=0; last_grant=DRAIN.
  - All outputs 0, including acc_ovf, drain_data and all mem_*.
  - Reset mid-transaction aborts it with no write.
- SRAM outputs are combinational from state and latched operands; mem_en=0 in IDLE.
- FSM states: IDLE, ACC_RD, ACC_WR, DRN_RD, DRN_CAP.
- Eligibility in IDLE:
  - acc_elig = acc_req.
  - drn_elig = drain_busy & remaining!=0 & !drain_valid.
- Grant in IDLE:
  - Only one eligible: grant it.
  - Both eligible: grant the one opposite last_grant, and update last_grant.
  - On grant, latch acc_addr, acc_data and acc_first.
- Accumulate path:
  - acc_first=1: IDLE→ACC_WR. Write acc_data.
  - acc_first=0: IDLE→ACC_RD (mem_en=1, we=0, addr=acc_addr)→ACC_WR. Write mem_rdata+acc_data.
  - ACC_WR: mem_en=1, we=1, acc_ack=1, then →IDLE.
  - Latency from grant to ack: 1 cycle (first) or 2 cycles.
  - The requester drops acc_req on the ack edge.
  - The sum wraps modulo 2^DATA_W. Signed overflow sets acc_ovf, which clears only on reset.
- Drain path:
  - drain_start while !drain_busy: ptr=0, remaining=drain_len, drain_busy=1 on the next cycle.
  - drain_start while busy is ignored.
  - drain_len=0: drain_done pulses the next cycle, drain_busy never rises, no memory access.
  - DRN_RD: mem read at ptr, then →DRN_CAP.
  - DRN_CAP:
    - drain_data<=mem_rdata, drain_valid<=1.
    - drain_last<=(remaining==1); ptr++, remaining--.
    - If CLEAR_ON_DRAIN: mem_en=1, we=1, addr=old ptr, wdata=0.
    - Then →IDLE.
  - drain_valid holds, with stable data, until drain_valid&drain_ready.
  - On acceptance with drain_last=1: drain_done=1 for one cycle, and drain_busy, drain_valid and drain_last clear on the same edge.
- Arbitration fairness:
  - While drain_valid waits on backpressure, the accumulate path keeps full access to memory.
  - Neither requester waits more than one foreign transaction.
- An accumulate to an entry not yet drained is legal; the drained value reflects memory at DRN_RD.

Decomposition:
- Package psum_sched_pkg holds:
  - state encodings (IDLE..DRN_CAP, 3 bits);
  - grant encoding (GNT_ACC, GNT_DRAIN);
  - the ovf-detect helper function.
- One sub-module, psum_drain_out: output holding register with valid/ready/last, plus the drain_done pulse.
- The FSM, arbiter and address counter stay in the top module.

Test Plan:
1. acc_first=1, addr=3, data=5, then acc_first=0, addr=3, data=7 → ack at 1 and 2 cycles after grant; mem[3]=12.
2. mem[2]=0x7FFF, acc addr=2, data=1 → mem[2]=0x8000; acc_ovf=1 and stays 1 until reset.
3. mem[0..3]={1,2,3,4}, drain_len=4, drain_ready=1 → drain_data 1,2,3,4; drain_last on 4; drain_done pulse; mem[0..3]=0 with CLEAR_ON_DRAIN=1.
4. drain_ready=0 for 10 cycles during a drain, with acc_req pulses to addr 9 → drain_data stable; accumulates complete; drain resumes in order after ready.
5. acc_req and drain eligible continuously → grants alternate ACC, DRAIN, ACC, …; first grant is ACC after reset.
6. reset low in ACC_RD, and separately drain_len=0 → no write to memory and all outputs 0; len=0 gives a single done pulse and no mem_en.
